motoro3_ramp_ctrl: RTL

Speed/direction sequencer placed in front of the three-phase motor top (m3start / m3invOrStop / m3freq inputs). It accepts target speed and direction commands over a valid/ready handshake. It ramps the commanded frequency at a programmable slew rate. A direction reversal or stop is always executed as decelerate → timed brake → (re-ramp | idle), so the motor never sees an abrupt reversal.

---
 rtl/motoro3_pkg.sv | 20 ++
 rtl/motoro3_ramp_tick.sv | 30 +++
 rtl/motoro3_ramp_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/motoro3_pkg.sv
// Shared types and constants for the three-phase motor ramp sequencer.
package motoro3_pkg;

  localparam int FREQ_W   = 10;
  localparam int MAX_FREQ = 1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DECEL = 3'd3,
    ST_BRAKE = 3'd4
  } state_t;

  function automatic logic [FREQ_W-1:0] clamp_freq(input logic [FREQ_W-1:0] f,
                                                   input logic [FREQ_W-1:0] lim);
    return (f > lim) ? lim : f;
  endfunction

endpackage

// File: rtl/motoro3_ramp_tick.sv
// Ramp prescaler: emits a one-cycle tick every RAMP_DIV cycles, restartable.
// Latency: first tick lands RAMP_DIV cycles after a restart cycle.
// Backpressure: none; free-running counter.
module motoro3_ramp_tick #(
  parameter int RAMP_DIV = 10000
) (
  input  logic clk,
  input  logic nRst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RAMP_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/motoro3_ramp_ctrl.sv
// Speed/direction sequencer: ramps frequency, reverses/stops via decel->brake.
// Latency: outputs registered, one cycle after the accepting/transition edge.
// Backpressure: cmdReady low during BRAKE or while eStop is asserted.
module motoro3_ramp_ctrl #(
  parameter int RAMP_DIV  = 10000,
  parameter int RAMP_STEP = 1,
  parameter int MIN_FREQ  = 1,
  parameter int BRAKE_CYC = 500000,
  parameter int MAX_FREQ  = motoro3_pkg::MAX_FREQ
) (
  input  logic                          clk,
  input  logic                          nRst,
  input  logic                          cmdValid,
  output logic                          cmdReady,
  input  logic [motoro3_pkg::FREQ_W-1:0] cmdFreq,
  input  logic                          cmdDir,
  input  logic                          eStop,
  output logic                          m3start,
  output logic                          m3invOrStop,
  output logic [motoro3_pkg::FREQ_W-1:0] m3freq,
  output logic                          atSpeed,
  output logic                          busy,
  output logic [2:0]                    state
);

  import motoro3_pkg::*;

  localparam int BRK_W = (BRAKE_CYC > 1) ? $clog2(BRAKE_CYC) : 1;
  localparam logic [BRK_W-1:0]  BRK_LOAD = BRK_W'(BRAKE_CYC - 1);
  localparam logic [FREQ_W-1:0] MIN_F    = FREQ_W'(MIN_FREQ);
  localparam logic [FREQ_W-1:0] STEP_F   = FREQ_W'(RAMP_STEP);
  localparam logic [FREQ_W-1:0] MAX_F    = FREQ_W'(MAX_FREQ);
  localparam logic [FREQ_W:0]   MIN_X    = (FREQ_W+1)'(MIN_FREQ);
  localparam logic [FREQ_W:0]   STEP_X   = (FREQ_W+1)'(RAMP_STEP);

  state_t             st, st_nxt;
  logic [FREQ_W-1:0]  cur_freq, cur_freq_nxt;
  logic               cur_dir, cur_dir_nxt;
  logic [FREQ_W-1:0]  tgt_freq, tgt_freq_nxt;
  logic               tgt_dir, tgt_dir_nxt;
  logic [BRK_W-1:0]   brake_cnt, brake_cnt_nxt;

  logic               tick;
  logic               restart;
  logic               hs;
  logic [FREQ_W-1:0]  cmd_clamped;
  logic [FREQ_W-1:0]  goal;
  logic [FREQ_W:0]    cur_x, goal_x, up_x;
  logic [FREQ_W-1:0]  dn;
  logic [FREQ_W-1:0]  ramp_val, decel_val;
  logic               retarget_stop;
  logic               inv_nxt;
  logic [FREQ_W-1:0]  freq_nxt;

  motoro3_ramp_tick #(
    .RAMP_DIV(RAMP_DIV)
  ) u_tick (
    .clk    (clk),
    .nRst   (nRst),
    .restart(restart),
    .tick   (tick)
  );

  assign cmdReady    = !eStop && (st != ST_BRAKE);
  assign hs          = cmdValid && cmdReady;
  assign cmd_clamped = clamp_freq(cmdFreq, MAX_F);
  assign state       = st;

  // 11-bit comparisons keep curFreq +/- RAMP_STEP from wrapping near the rails.
  always_comb begin
    goal      = (tgt_freq < MIN_F) ? MIN_F : tgt_freq;
    cur_x     = {1'b0, cur_freq};
    goal_x    = {1'b0, goal};
    up_x      = cur_x + STEP_X;
    dn        = cur_freq - STEP_F;
    if (cur_x < goal_x) begin
      ramp_val = (up_x >= goal_x) ? goal : up_x[FREQ_W-1:0];
    end else if (cur_x > goal_x + STEP_X) begin
      ramp_val = dn;
    end else begin
      ramp_val = goal;
    end
    decel_val     = (cur_x > MIN_X + STEP_X) ? dn : MIN_F;
    retarget_stop = (tgt_freq == '0) || (tgt_dir != cur_dir);
  end

  always_comb begin
    st_nxt        = st;
    cur_freq_nxt  = cur_freq;
    cur_dir_nxt   = cur_dir;
    tgt_freq_nxt  = tgt_freq;
    tgt_dir_nxt   = tgt_dir;
    brake_cnt_nxt = brake_cnt;

    if (hs) begin
      tgt_freq_nxt = cmd_clamped;
      tgt_dir_nxt  = cmdDir;
    end

    case (st)
      ST_IDLE: begin
        if (hs && cmd_clamped != '0) begin
          st_nxt       = ST_RAMP;
          cur_freq_nxt = MIN_F;
          cur_dir_nxt  = cmdDir;
        end
      end
      ST_RAMP: begin
        if (tick) begin
          if (retarget_stop) begin
            st_nxt = ST_DECEL;
          end else begin
            cur_freq_nxt = ramp_val;
            if (ramp_val == goal) st_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (retarget_stop) begin
          st_nxt = ST_DECEL;
        end else if (goal != cur_freq) begin
          st_nxt = ST_RAMP;
        end
      end
      ST_DECEL: begin
        if (tick) begin
          if (cur_freq == MIN_F) begin
            st_nxt        = ST_BRAKE;
            brake_cnt_nxt = BRK_LOAD;
          end else begin
            cur_freq_nxt = decel_val;
          end
        end
      end
      ST_BRAKE: begin
        if (brake_cnt == '0) begin
          if (tgt_freq == '0) begin
            st_nxt       = ST_IDLE;
            cur_freq_nxt = '0;
          end else begin
            st_nxt       = ST_RAMP;
            cur_dir_nxt  = tgt_dir;
            cur_freq_nxt = MIN_F;
          end
        end else begin
          brake_cnt_nxt = brake_cnt - 1'b1;
        end
      end
      default: st_nxt = ST_IDLE;
    endcase

    // Emergency stop overrides everything except an idle motor.
    if (eStop && st != ST_IDLE) begin
      st_nxt        = ST_BRAKE;
      brake_cnt_nxt = BRK_LOAD;
      tgt_freq_nxt  = '0;
    end

    restart = (st_nxt != st) && (st_nxt == ST_RAMP || st_nxt == ST_DECEL);

    case (st_nxt)
      ST_IDLE: begin
        inv_nxt  = 1'b0;
        freq_nxt = '0;
      end
      ST_BRAKE: begin
        inv_nxt  = 1'b1;
        freq_nxt = '0;
      end
      default: begin
        inv_nxt  = cur_dir_nxt;
        freq_nxt = cur_freq_nxt;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      st          <= ST_IDLE;
      cur_freq    <= '0;
      cur_dir     <= 1'b0;
      tgt_freq    <= '0;
      tgt_dir     <= 1'b0;
      brake_cnt   <= '0;
      m3start     <= 1'b0;
      m3invOrStop <= 1'b0;
      m3freq      <= '0;
      atSpeed     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      st          <= st_nxt;
      cur_freq    <= cur_freq_nxt;
      cur_dir     <= cur_dir_nxt;
      tgt_freq    <= tgt_freq_nxt;
      tgt_dir     <= tgt_dir_nxt;
      brake_cnt   <= brake_cnt_nxt;
      m3start     <= (st_nxt != ST_IDLE);
      m3invOrStop <= inv_nxt;
      m3freq      <= freq_nxt;
      atSpeed     <= (st_nxt == ST_RUN);
      busy        <= (st_nxt == ST_RAMP) || (st_nxt == ST_DECEL) || (st_nxt == ST_BRAKE);
    end
  end

endmodule
